// File: rtl/v_reg_drain_if.sv
// Interface bundling the start command, register-file read port and output
// beat stream of the vector register drain.
interface v_reg_drain_if #(
    parameter int unsigned vlen_p  = 8,
    parameter int unsigned vdw_p   = 32,
    parameter int unsigned lanes_p = 4
);
    localparam int unsigned addr_width_lp = $clog2(vlen_p);
    localparam int unsigned vl_width_lp   = $clog2(vlen_p + 1);

    logic                             start_v_i;
    logic                             start_ready_o;
    logic [vl_width_lp-1:0]           vl_i;
    logic [lanes_p*addr_width_lp-1:0] r_addr_o;
    logic [lanes_p*vdw_p-1:0]         r_data_i;
    logic                             data_v_o;
    logic                             data_ready_i;
    logic [lanes_p*vdw_p-1:0]         data_o;
    logic [lanes_p-1:0]               data_mask_o;
    logic                             data_last_o;
    logic                             busy_o;

    // Drain side: takes commands and read data, drives addresses and beats.
    modport master (
        input  start_v_i, vl_i, r_data_i, data_ready_i,
        output start_ready_o, r_addr_o, data_v_o, data_o, data_mask_o,
               data_last_o, busy_o
    );

    // Environment side: issues commands, serves reads, consumes beats.
    modport slave (
        output start_v_i, vl_i, r_data_i, data_ready_i,
        input  start_ready_o, r_addr_o, data_v_o, data_o, data_mask_o,
               data_last_o, busy_o
    );
endinterface

// File: rtl/v_reg_drain.sv
// Read-side initiator for the banked vector register file: walks the first vl
// elements lanes_p at a time and presents them as a registered beat stream.
module v_reg_drain #(
    parameter int unsigned vlen_p  = 8,
    parameter int unsigned vdw_p   = 32,
    parameter int unsigned lanes_p = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    v_reg_drain_if.master bus
);
    localparam int unsigned addr_width_lp = $clog2(vlen_p);
    localparam int unsigned vl_width_lp   = $clog2(vlen_p + 1);
    localparam int unsigned beats_lp      = vlen_p / lanes_p;
    localparam int unsigned lg_lanes_lp   = $clog2(lanes_p);
    localparam int unsigned bw_lp         = $clog2(beats_lp + 1);
    localparam int unsigned ew_lp         = vl_width_lp + 1;

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    state_e                           r_state;
    state_e                           w_state_nxt;
    logic [bw_lp-1:0]                 r_b;
    logic [vl_width_lp-1:0]           r_vl;
    logic                             r_data_v;
    logic [lanes_p*vdw_p-1:0]         r_data;
    logic [lanes_p-1:0]               r_mask;
    logic                             r_last;

    logic [vl_width_lp-1:0]           w_vl_clamp;
    logic [ew_lp-1:0]                 w_nbeats_full;
    logic [bw_lp-1:0]                 w_nbeats;
    logic [lanes_p*addr_width_lp-1:0] w_addr;
    logic [lanes_p-1:0]               w_mask;
    logic                             w_load;
    logic                             w_pop;
    logic                             w_start_ready;
    logic                             w_busy;

    assign w_vl_clamp    = (bus.vl_i > vl_width_lp'(vlen_p)) ? vl_width_lp'(vlen_p) : bus.vl_i;
    assign w_nbeats_full = ({1'b0, r_vl} + ew_lp'(lanes_p - 1)) >> lg_lanes_lp;
    assign w_nbeats      = bw_lp'(w_nbeats_full);

    // Per-lane element index: address to the bank and liveness against vl.
    always_comb begin
        w_addr = '0;
        w_mask = '0;
        for (int unsigned i = 0; i < lanes_p; i++) begin
            w_addr[i*addr_width_lp +: addr_width_lp] =
                (addr_width_lp'(r_b) << lg_lanes_lp) + addr_width_lp'(i);
            w_mask[i] = ((ew_lp'(r_b) << lg_lanes_lp) + ew_lp'(i)) < {1'b0, r_vl};
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state, handshake and load/pop decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_ready = 1'b0;
        w_busy        = 1'b0;
        w_pop         = r_data_v && bus.data_ready_i;
        w_load        = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_ready = 1'b1;
                if (bus.start_v_i && (w_vl_clamp != '0)) w_state_nxt = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                w_load = (r_b < w_nbeats) && (!r_data_v || bus.data_ready_i);
                if (w_pop && r_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat counter, command length and output beat registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_b      <= '0;
            r_vl     <= '0;
            r_data_v <= 1'b0;
            r_data   <= '0;
            r_mask   <= '0;
            r_last   <= 1'b0;
        end else begin
            // b is rewound on the way back to IDLE so the idle address is lane-aligned at 0.
            if (r_state == IDLE && bus.start_v_i) begin
                r_vl <= w_vl_clamp;
                r_b  <= '0;
            end else if (w_load) begin
                r_b <= r_b + bw_lp'(1);
            end else if (r_state == RUN && w_state_nxt == IDLE) begin
                r_b <= '0;
            end

            if (w_load) begin
                for (int unsigned i = 0; i < lanes_p; i++) begin
                    r_data[i*vdw_p +: vdw_p] <= w_mask[i] ? bus.r_data_i[i*vdw_p +: vdw_p] : '0;
                end
                r_mask   <= w_mask;
                r_last   <= (r_b == (w_nbeats - bw_lp'(1)));
                r_data_v <= 1'b1;
            end else if (w_pop) begin
                r_data_v <= 1'b0;
            end
        end
    end

    assign bus.start_ready_o = w_start_ready;
    assign bus.busy_o        = w_busy;
    assign bus.r_addr_o      = w_addr;
    assign bus.data_v_o      = r_data_v;
    assign bus.data_o        = r_data;
    assign bus.data_mask_o   = r_mask;
    assign bus.data_last_o   = r_last;
endmodule

// File: tb/tb_v_reg_drain.sv
// Scoreboard bench for v_reg_drain: stimulus pushes expected beats, a monitor
// pops and compares each beat the DUT hands over.
module tb_v_reg_drain;
    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   mask;
        logic         last;
    } beat_t;

    localparam logic [127:0] B0    = 128'hD0000003_D0000002_D0000001_D0000000;
    localparam logic [127:0] B1    = 128'hD0000007_D0000006_D0000005_D0000004;
    localparam logic [127:0] B1_V5 = 128'h00000000_00000000_00000000_D0000004;
    localparam logic [11:0]  A_LO  = 12'h688;  // lanes {3,2,1,0}
    localparam logic [11:0]  A_HI  = 12'hFAC;  // lanes {7,6,5,4}

    logic        clk;
    logic        reset_n;
    logic [31:0] mem [0:7];
    beat_t       q[$];
    int          checks;
    int          failures;

    v_reg_drain_if #(.vlen_p(8), .vdw_p(32), .lanes_p(4)) bif ();

    v_reg_drain #(.vlen_p(8), .vdw_p(32), .lanes_p(4)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Banked register file model: combinational read per lane.
    always_comb begin
        bif.r_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            bif.r_data_i[i*32 +: 32] = mem[bif.r_addr_o[i*3 +: 3]];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic [3:0] m, input logic l);
        beat_t b;
        b.data = d;
        b.mask = m;
        b.last = l;
        q.push_back(b);
    endtask

    task automatic start(input logic [3:0] vl);
        bif.start_v_i = 1'b1;
        bif.vl_i      = vl;
        tick();
        bif.start_v_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50 && !bif.start_ready_o; n++) tick();
        chk("idle_reached", bif.start_ready_o, 1'b1);
        chk("idle_no_valid", bif.data_v_o, 1'b0);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && bif.data_v_o && bif.data_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h required=none", bif.data_o);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_data", bif.data_o, e.data);
                chk("beat_mask", bif.data_mask_o, e.mask);
                chk("beat_last", bif.data_last_o, e.last);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int e = 0; e < 8; e++) mem[e] = 32'hD000_0000 + e;
        reset_n          = 1'b0;
        bif.start_v_i    = 1'b0;
        bif.vl_i         = '0;
        bif.data_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", bif.data_v_o, 1'b0);
        chk("rst_data", bif.data_o, '0);
        chk("rst_mask", bif.data_mask_o, 4'b0000);
        chk("rst_last", bif.data_last_o, 1'b0);
        chk("rst_busy", bif.busy_o, 1'b0);
        chk("rst_start_ready", bif.start_ready_o, 1'b1);
        chk("rst_addr", bif.r_addr_o, A_LO);
        reset_n = 1'b1;
        tick();

        // 1: full vector, always ready
        bif.data_ready_i = 1'b1;
        push(B0, 4'hF, 1'b0);
        push(B1, 4'hF, 1'b1);
        start(4'd8);
        chk("t1_busy", bif.busy_o, 1'b1);
        chk("t1_start_ready", bif.start_ready_o, 1'b0);
        chk("t1_no_valid_yet", bif.data_v_o, 1'b0);
        chk("t1_addr0", bif.r_addr_o, A_LO);
        tick();
        chk("t1_beat0_valid", bif.data_v_o, 1'b1);
        chk("t1_addr1", bif.r_addr_o, A_HI);
        tick();
        chk("t1_beat1_valid", bif.data_v_o, 1'b1);
        chk("t1_beat1_last", bif.data_last_o, 1'b1);
        tick();
        chk("t1_done_valid", bif.data_v_o, 1'b0);
        chk("t1_done_ready", bif.start_ready_o, 1'b1);
        chk("t1_done_busy", bif.busy_o, 1'b0);

        // 2: partial last beat
        push(B0, 4'hF, 1'b0);
        push(B1_V5, 4'b0001, 1'b1);
        start(4'd5);
        wait_idle();

        // 3: zero-length command
        start(4'd0);
        for (int n = 0; n < 4; n++) begin
            chk("t3_valid", bif.data_v_o, 1'b0);
            chk("t3_busy", bif.busy_o, 1'b0);
            chk("t3_start_ready", bif.start_ready_o, 1'b1);
            tick();
        end

        // 4: backpressure on beat 0
        bif.data_ready_i = 1'b0;
        push(B0, 4'hF, 1'b0);
        push(B1, 4'hF, 1'b1);
        start(4'd8);
        tick();
        for (int n = 0; n < 3; n++) begin
            chk("t4_stall_valid", bif.data_v_o, 1'b1);
            chk("t4_stall_data", bif.data_o, B0);
            chk("t4_stall_mask", bif.data_mask_o, 4'hF);
            chk("t4_stall_last", bif.data_last_o, 1'b0);
            chk("t4_stall_addr", bif.r_addr_o, A_HI);
            tick();
        end
        bif.data_ready_i = 1'b1;
        tick();
        chk("t4_beat1_valid", bif.data_v_o, 1'b1);
        chk("t4_beat1_data", bif.data_o, B1);
        chk("t4_beat1_last", bif.data_last_o, 1'b1);
        wait_idle();

        // 5: asynchronous reset mid-command
        bif.data_ready_i = 1'b0;
        start(4'd8);
        tick();
        chk("t5_beat0_valid", bif.data_v_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", bif.data_v_o, 1'b0);
        chk("t5_async_busy", bif.busy_o, 1'b0);
        chk("t5_async_ready", bif.start_ready_o, 1'b1);
        chk("t5_async_addr", bif.r_addr_o, A_LO);
        chk("t5_async_mask", bif.data_mask_o, 4'b0000);
        tick();
        reset_n = 1'b1;
        bif.data_ready_i = 1'b1;
        tick();
        push(B0, 4'hF, 1'b1);
        start(4'd4);
        wait_idle();

        // 6: clamp of oversize vl and start ignored while running
        push(B0, 4'hF, 1'b0);
        push(B1, 4'hF, 1'b1);
        start(4'd12);
        bif.start_v_i = 1'b1;
        bif.vl_i      = 4'd4;
        tick();
        bif.start_v_i = 1'b0;
        wait_idle();
        for (int n = 0; n < 3; n++) begin
            chk("t6_quiet_valid", bif.data_v_o, 1'b0);
            tick();
        end
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
